// File: rtl/inc_step_counter.sv
// Registered WIDTH-bit up/down counter with programmable step, parallel load, wrap/saturate and carry/borrow pulse.
// Optional sticky overflow flag with clear input is enabled by INC_STEP_COUNTER_OVF_STICKY_EN.
module inc_step_counter #(
   parameter int unsigned WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
`ifdef INC_STEP_COUNTER_OVF_STICKY_EN
   input  logic             ovf_clr,
   output logic             ovf_sticky,
`endif
   output logic [WIDTH-1:0] count,
   output logic             cout,
   output logic             zero
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] count_nxt;
   logic             cout_nxt;

   // The extra MSB of each result is the carry (add) or borrow (subtract).
   assign sum  = {1'b0, count} + {1'b0, step};
   assign diff = {1'b0, count} - {1'b0, step};

   always_comb begin
      count_nxt = count;
      cout_nxt  = 1'b0;
      if (load) begin
         count_nxt = load_val;
      end else if (en) begin
         if (up) begin
            cout_nxt  = sum[WIDTH];
            count_nxt = (sum[WIDTH] && sat_mode) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
         end else begin
            cout_nxt  = diff[WIDTH];
            count_nxt = (diff[WIDTH] && sat_mode) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RESET_VAL;
         cout  <= 1'b0;
         zero  <= (RESET_VAL == '0);
      end else begin
         count <= count_nxt;
         cout  <= cout_nxt;
         zero  <= (count_nxt == '0);
      end
   end

`ifdef INC_STEP_COUNTER_OVF_STICKY_EN
   // A new overflow wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else begin
         ovf_sticky <= cout_nxt | (ovf_sticky & ~ovf_clr);
      end
   end
`endif

endmodule

// File: tb/tb_inc_step_counter.sv
// Directed bench for inc_step_counter (WIDTH=8, RESET_VAL=0), including the sticky flag when enabled.
module tb_inc_step_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic [7:0] step;
   logic       load;
   logic [7:0] load_val;
   logic       sat_mode;
   logic [7:0] count;
   logic       cout;
   logic       zero;
`ifdef INC_STEP_COUNTER_OVF_STICKY_EN
   logic       ovf_clr;
   logic       ovf_sticky;
`endif

   int tests_run;
   int tests_failed;

   inc_step_counter #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .step     (step),
      .load     (load),
      .load_val (load_val),
      .sat_mode (sat_mode),
`ifdef INC_STEP_COUNTER_OVF_STICKY_EN
      .ovf_clr    (ovf_clr),
      .ovf_sticky (ovf_sticky),
`endif
      .count    (count),
      .cout     (cout),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_val = v; en = 1'b0;
      tick();
      load = 1'b0;
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1; en = 1'b0; up = 1'b0; step = 8'h00;
      load = 1'b0; load_val = 8'h00; sat_mode = 1'b0;
`ifdef INC_STEP_COUNTER_OVF_STICKY_EN
      ovf_clr = 1'b0;
`endif
      #12;
      chk("rst_count", count, 8'h00);
      chk("rst_zero", zero, 1'b1);
      chk("rst_cout", cout, 1'b0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("post_rst_count", count, 8'h00);
      chk("post_rst_zero", zero, 1'b1);

      // async reset mid-count
      do_load(8'h37);
      chk("load37_count", count, 8'h37);
      chk("load37_zero", zero, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", count, 8'h00);
      chk("async_rst_zero", zero, 1'b1);
      #1 rst = 1'b0;

      // wrap up
      do_load(8'hFE);
      en = 1'b1; up = 1'b1; step = 8'h03; sat_mode = 1'b0;
      tick();
      chk("wrap_up_count", count, 8'h01);
      chk("wrap_up_cout", cout, 1'b1);
      chk("wrap_up_zero", zero, 1'b0);
      en = 1'b0;
      tick();
      chk("idle_cout", cout, 1'b0);
      chk("idle_count", count, 8'h01);

      // saturate up
      do_load(8'hFE);
      en = 1'b1; up = 1'b1; step = 8'h03; sat_mode = 1'b1;
      tick();
      chk("sat_up_count", count, 8'hFF);
      chk("sat_up_cout", cout, 1'b1);
      tick();
      chk("sat_up2_count", count, 8'hFF);
      chk("sat_up2_cout", cout, 1'b1);
      en = 1'b0;

      // down with borrow
      do_load(8'h02);
      en = 1'b1; up = 1'b0; step = 8'h02; sat_mode = 1'b0;
      tick();
      chk("down_count", count, 8'h00);
      chk("down_zero", zero, 1'b1);
      chk("down_cout", cout, 1'b0);
      step = 8'h01;
      tick();
      chk("borrow_wrap_count", count, 8'hFF);
      chk("borrow_wrap_cout", cout, 1'b1);
      chk("borrow_wrap_zero", zero, 1'b0);
      do_load(8'h00);
      chk("load0_cout", cout, 1'b0);
      en = 1'b1; up = 1'b0; step = 8'h01; sat_mode = 1'b1;
      tick();
      chk("borrow_sat_count", count, 8'h00);
      chk("borrow_sat_cout", cout, 1'b1);
      chk("borrow_sat_zero", zero, 1'b1);

      // priority load over en, then zero step
      load = 1'b1; load_val = 8'h55; en = 1'b1; up = 1'b1; step = 8'h10; sat_mode = 1'b0;
      tick();
      chk("prio_count", count, 8'h55);
      chk("prio_cout", cout, 1'b0);
      load = 1'b0; step = 8'h00;
      tick();
      chk("step0_count", count, 8'h55);
      chk("step0_cout", cout, 1'b0);
      step = 8'h10;
      tick();
      chk("plain_up_count", count, 8'h65);
      chk("plain_up_cout", cout, 1'b0);
      en = 1'b0;
      tick();
      chk("hold_count", count, 8'h65);

`ifdef INC_STEP_COUNTER_OVF_STICKY_EN
      rst = 1'b1; #1; rst = 1'b0;
      chk("sticky_rst", ovf_sticky, 1'b0);
      do_load(8'hFF);
      en = 1'b1; up = 1'b1; step = 8'h01; sat_mode = 1'b0;
      tick();
      chk("sticky_set", ovf_sticky, 1'b1);
      en = 1'b0;
      tick();
      chk("sticky_idle", ovf_sticky, 1'b1);
      do_load(8'h10);
      chk("sticky_load", ovf_sticky, 1'b1);
      ovf_clr = 1'b1;
      tick();
      chk("sticky_clr", ovf_sticky, 1'b0);
      do_load(8'hFF);
      chk("sticky_clr_load", ovf_sticky, 1'b0);
      en = 1'b1; up = 1'b1; step = 8'h01;
      tick();
      chk("sticky_set_wins", ovf_sticky, 1'b1);
      en = 1'b0; ovf_clr = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
